// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared selector encodings and helpers for the forwarding/hazard unit.
// Imported by the tracker entry, the interface users and the top.
package forwarding_hazard_unit_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;

    localparam int REG_ZERO = 0;

    // The EX producer is younger, so it wins over MEM.
    function automatic logic [1:0] fwd_sel(
        input logic ex_hit,
        input logic mem_hit
    );
        logic [1:0] sel;
        sel = FWD_REGFILE;
        if (ex_hit)
            sel = FWD_EXMEM;
        else if (mem_hit)
            sel = FWD_MEMWB;
        return sel;
    endfunction

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// Decode-side bundle: ID instruction info in, mux selectors and stall out.
// master = decode/pipeline control, slave = forwarding_hazard_unit.
interface forwarding_hazard_unit_if #(
    parameter int REG_ADDR_BITS = 5
);
    logic                     hold_i;
    logic                     flush_i;
    logic                     id_valid_i;
    logic [REG_ADDR_BITS-1:0] id_rs_i;
    logic [REG_ADDR_BITS-1:0] id_rt_i;
    logic                     id_uses_rs_i;
    logic                     id_uses_rt_i;
    logic                     id_reg_write_i;
    logic                     id_mem_read_i;
    logic [REG_ADDR_BITS-1:0] id_write_reg_i;
    logic [1:0]               forward_a_o;
    logic [1:0]               forward_b_o;
    logic                     stall_o;
    logic                     bubble_o;

    modport master (
        output hold_i, flush_i, id_valid_i,
        output id_rs_i, id_rt_i,
        output id_uses_rs_i, id_uses_rt_i,
        output id_reg_write_i, id_mem_read_i,
        output id_write_reg_i,
        input  forward_a_o, forward_b_o,
        input  stall_o, bubble_o
    );

    modport slave (
        input  hold_i, flush_i, id_valid_i,
        input  id_rs_i, id_rt_i,
        input  id_uses_rs_i, id_uses_rt_i,
        input  id_reg_write_i, id_mem_read_i,
        input  id_write_reg_i,
        output forward_a_o, forward_b_o,
        output stall_o, bubble_o
    );
endinterface

// File: rtl/forwarding_hazard_unit_entry.sv
// One in-flight tracker stage: {valid, reg_write, mem_read, dest}.
// Holds on hold_i; clear_i loads an invalid entry (bubble).
module hazard_track_entry
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         hold_i,
    input  logic         clear_i,
    input  logic         valid_i,
    input  logic         reg_write_i,
    input  logic         mem_read_i,
    input  logic [W-1:0] dest_i,
    output logic         valid_o,
    output logic         reg_write_o,
    output logic         mem_read_o,
    output logic [W-1:0] dest_o,
    output logic         writer_o
);

    logic         valid_q, valid_d;
    logic         reg_write_q, reg_write_d;
    logic         mem_read_q, mem_read_d;
    logic [W-1:0] dest_q, dest_d;

    always_comb begin
        valid_d     = valid_i & ~clear_i;
        reg_write_d = reg_write_i;
        mem_read_d  = mem_read_i;
        dest_d      = dest_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            dest_q      <= '0;
        end else if (!hold_i) begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            dest_q      <= dest_d;
        end
    end

    assign valid_o     = valid_q;
    assign reg_write_o = reg_write_q;
    assign mem_read_o  = mem_read_q;
    assign dest_o      = dest_q;
    assign writer_o    = valid_q & reg_write_q & (dest_q != W'(REG_ZERO));

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Tracks EX/MEM destinations, drives registered ALU operand selectors
// and a combinational load-use (or no-forwarding) stall/bubble.
module forwarding_hazard_unit
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_BITS = 5,
    parameter int FORWARD_EN    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    forwarding_hazard_unit_if.slave bus
);

    localparam int W = REG_ADDR_BITS;

    logic         id_live;
    logic         hazard;
    logic         ex_valid, ex_rw, ex_mr, ex_writer;
    logic [W-1:0] ex_dest;
    logic         mem_valid, mem_rw, mem_mr, mem_writer;
    logic [W-1:0] mem_dest;
    logic         ex_hit_rs, ex_hit_rt;
    logic         mem_hit_rs, mem_hit_rt;
    logic [1:0]   sel_a, sel_b;
    logic [1:0]   fwd_a_q, fwd_a_d;
    logic [1:0]   fwd_b_q, fwd_b_d;
    logic         unused;

    assign id_live = bus.id_valid_i & ~bus.flush_i;

    hazard_track_entry #(.W(W)) u_ex (
        .clk         (clk),
        .reset       (reset),
        .hold_i      (bus.hold_i),
        .clear_i     (hazard),
        .valid_i     (id_live),
        .reg_write_i (bus.id_reg_write_i),
        .mem_read_i  (bus.id_mem_read_i),
        .dest_i      (bus.id_write_reg_i),
        .valid_o     (ex_valid),
        .reg_write_o (ex_rw),
        .mem_read_o  (ex_mr),
        .dest_o      (ex_dest),
        .writer_o    (ex_writer)
    );

    hazard_track_entry #(.W(W)) u_mem (
        .clk         (clk),
        .reset       (reset),
        .hold_i      (bus.hold_i),
        .clear_i     (1'b0),
        .valid_i     (ex_valid),
        .reg_write_i (ex_rw),
        .mem_read_i  (ex_mr),
        .dest_i      (ex_dest),
        .valid_o     (mem_valid),
        .reg_write_o (mem_rw),
        .mem_read_o  (mem_mr),
        .dest_o      (mem_dest),
        .writer_o    (mem_writer)
    );

    // The MEM load flag and raw valid/write bits are not needed past WB.
    assign unused = &{1'b0, mem_valid, mem_rw, mem_mr};

    always_comb begin
        ex_hit_rs  = ex_writer & bus.id_uses_rs_i
                   & (bus.id_rs_i == ex_dest);
        ex_hit_rt  = ex_writer & bus.id_uses_rt_i
                   & (bus.id_rt_i == ex_dest);
        mem_hit_rs = mem_writer & bus.id_uses_rs_i
                   & (bus.id_rs_i == mem_dest);
        mem_hit_rt = mem_writer & bus.id_uses_rt_i
                   & (bus.id_rt_i == mem_dest);
    end

    always_comb begin
        hazard = 1'b0;
        if (FORWARD_EN != 0)
            hazard = id_live & ex_mr & (ex_hit_rs | ex_hit_rt);
        else
            hazard = id_live & (ex_hit_rs | ex_hit_rt
                              | mem_hit_rs | mem_hit_rt);
    end

    always_comb begin
        sel_a = FWD_REGFILE;
        sel_b = FWD_REGFILE;
        if (FORWARD_EN != 0 && id_live) begin
            if (bus.id_rs_i != W'(REG_ZERO))
                sel_a = fwd_sel(ex_hit_rs, mem_hit_rs);
            if (bus.id_rt_i != W'(REG_ZERO))
                sel_b = fwd_sel(ex_hit_rt, mem_hit_rt);
        end
        fwd_a_d = hazard ? FWD_REGFILE : sel_a;
        fwd_b_d = hazard ? FWD_REGFILE : sel_b;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_a_q <= FWD_REGFILE;
            fwd_b_q <= FWD_REGFILE;
        end else if (!bus.hold_i) begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign bus.forward_a_o = fwd_a_q;
    assign bus.forward_b_o = fwd_b_q;
    assign bus.stall_o     = hazard & ~bus.hold_i;
    assign bus.bubble_o    = hazard & ~bus.hold_i;

endmodule
